// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
//
// MEM-stage load/store unit. It sits between the EX/MEM pipeline register and
// MEMWBreg. The unit turns the effective address and store data of the
// instruction in MEM into a single word-aligned bus transaction. The
// transaction uses a valid/ready request channel and a valid-only response
// channel. While the transaction is outstanding the unit stalls the front of
// the pipe. The loaded word is held on RamDataM so that MEMWBreg can capture it.
//
// Build option: MEM_TIMEOUT_EN
//   - Defined: a response watchdog of TIMEOUT_CYCLES cycles is active.
//     BusErrM pulses when the watchdog fires.
//   - Undefined: WAIT waits for the response indefinitely, and BusErrM is 0.
//
// Parameters
//   TIMEOUT_CYCLES  response wait limit in cycles (1..255, MEM_TIMEOUT_EN only)
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   AluOutM         effective byte address
//   StoreDataM      store data, LSB-justified
//   MemWriteM       unshifted store byte mask (0001 sb, 0011 sh, 1111 sw)
//   MemReadM        load request
//   LoadWidthM      00 byte, 01 half, 10/11 word
//   FlushM          squash the instruction in MEM
//   EnM             MEMWBreg enable; 0 holds the completed result
//   StallM          freeze IF..EX/MEM this cycle
//   RamDataM        raw loaded word (byte lane selection happens in WB)
//   AddrMisalignM   misaligned access; no bus transaction is issued
//   BusErrM         one-cycle response-timeout pulse
//   bus_req_*       request channel (valid/ready, we, addr, wdata, wstrb)
//   bus_rsp_*       response channel (valid, rdata)
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] AluOutM,
    input  logic [31:0] StoreDataM,
    input  logic [3:0]  MemWriteM,
    input  logic        MemReadM,
    input  logic [1:0]  LoadWidthM,
    input  logic        FlushM,
    input  logic        EnM,
    output logic        StallM,
    output logic [31:0] RamDataM,
    output logic        AddrMisalignM,
    output logic        BusErrM,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_we,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_wdata,
    output logic [3:0]  bus_req_wstrb,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Returns 1 when an access of the given width is not naturally aligned.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lsb);
        logic bad;
        case (width)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lsb[0];
            default: bad = (lsb != 2'b00);
        endcase
        return bad;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        drop_q, drop_d;
    logic        stall_s;
    logic        is_store_s;
    logic        mem_op_s;
    logic [1:0]  acc_width_s;
    logic        misalign_s;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       bus_err_q, bus_err_d;
`endif

    // Decode the access: a store takes priority over a load, and the width of
    // a store comes from its byte mask.
    always_comb begin
        is_store_s = |MemWriteM;
        mem_op_s   = (MemReadM | is_store_s) & ~FlushM;
        if (is_store_s) begin
            case (MemWriteM)
                4'b1111: acc_width_s = 2'b10;
                4'b0011: acc_width_s = 2'b01;
                default: acc_width_s = 2'b00;
            endcase
        end else begin
            acc_width_s = LoadWidthM;
        end
        misalign_s = is_misaligned(acc_width_s, AluOutM[1:0]);
    end

    // Next-state logic for the transaction FSM and the request/data registers.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        drop_d  = drop_q;
        stall_s = 1'b0;
`ifdef MEM_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        bus_err_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (mem_op_s && !misalign_s) begin
                    stall_s = 1'b1;
                    state_d = ST_REQ;
                    addr_d  = {AluOutM[31:2], 2'b00};
                    we_d    = is_store_s;
                    wdata_d = StoreDataM << {AluOutM[1:0], 3'b000};
                    wstrb_d = MemWriteM << AluOutM[1:0];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // The request stays valid until it is accepted, even after a
                // flush. The flush is remembered so that the response is dropped.
                stall_s = 1'b1;
                if (FlushM) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
                if (bus_req_ready) begin
                    state_d = ST_WAIT;
`ifdef MEM_TIMEOUT_EN
                    wait_cnt_d = 8'd0;
`endif
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                stall_s = 1'b1;
                if (bus_rsp_valid) begin
                    if (drop_q || FlushM) begin
                        drop_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        if (!we_q) begin
                            rdata_d = bus_rsp_rdata;
                        end else begin
                            rdata_d = rdata_q;
                        end
                        state_d = ST_DONE;
                    end
                end else begin
                    if (FlushM) begin
                        drop_d = 1'b1;
                    end else begin
                        drop_d = drop_q;
                    end
`ifdef MEM_TIMEOUT_EN
                    if (wait_cnt_q == TIMEOUT_LAST) begin
                        bus_err_d = 1'b1;
                        if (drop_q || FlushM) begin
                            drop_d  = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            rdata_d = 32'h0000_0000;
                            state_d = ST_DONE;
                        end
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
`else
                    state_d = ST_WAIT;
`endif
                end
            end
            ST_DONE: begin
                // The result is committed here. A flush has no effect, and no
                // new request is issued from this state.
                if (EnM) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'h0000_0000;
            we_q    <= 1'b0;
            wdata_q <= 32'h0000_0000;
            wstrb_q <= 4'b0000;
            rdata_q <= 32'h0000_0000;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            drop_q  <= drop_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Response watchdog counter and the one-cycle error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= 8'd0;
            bus_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end
    assign BusErrM = bus_err_q;
`else
    assign BusErrM = 1'b0;
`endif

    assign StallM        = stall_s;
    assign AddrMisalignM = (state_q == ST_IDLE) && mem_op_s && misalign_s;
    assign RamDataM      = rdata_q;
    assign bus_req_valid = (state_q == ST_REQ);
    assign bus_req_we    = we_q;
    assign bus_req_addr  = addr_q;
    assign bus_req_wdata = wdata_q;
    assign bus_req_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_lsu
//
// Directed bench for mem_stage_lsu. Inputs are driven 1 time unit after the
// rising edge. Outputs are compared 1 time unit later, well away from the
// next edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] AluOutM;
    logic [31:0] StoreDataM;
    logic [3:0]  MemWriteM;
    logic        MemReadM;
    logic [1:0]  LoadWidthM;
    logic        FlushM;
    logic        EnM;
    logic        StallM;
    logic [31:0] RamDataM;
    logic        AddrMisalignM;
    logic        BusErrM;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_we;
    logic [31:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic [3:0]  bus_req_wstrb;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;

    int num_checks = 0;
    int num_fails  = 0;
    int stall_cnt;

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .AluOutM       (AluOutM),
        .StoreDataM    (StoreDataM),
        .MemWriteM     (MemWriteM),
        .MemReadM      (MemReadM),
        .LoadWidthM    (LoadWidthM),
        .FlushM        (FlushM),
        .EnM           (EnM),
        .StallM        (StallM),
        .RamDataM      (RamDataM),
        .AddrMisalignM (AddrMisalignM),
        .BusErrM       (BusErrM),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_req_we    (bus_req_we),
        .bus_req_addr  (bus_req_addr),
        .bus_req_wdata (bus_req_wdata),
        .bus_req_wstrb (bus_req_wstrb),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_rdata (bus_rsp_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_nop();
        MemReadM  = 1'b0;
        MemWriteM = 4'b0000;
        FlushM    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        AluOutM       = 32'h0;
        StoreDataM    = 32'h0;
        LoadWidthM    = 2'b10;
        EnM           = 1'b1;
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rsp_rdata = 32'h0;
        set_nop();
        tick();
        tick();
        rst = 1'b0;
        settle();
        check_eq("rst_valid",    bus_req_valid, 32'd0);
        check_eq("rst_ramdata",  RamDataM,      32'd0);
        check_eq("rst_misalign", AddrMisalignM, 32'd0);
        check_eq("rst_buserr",   BusErrM,       32'd0);
        check_eq("rst_stall",    StallM,        32'd0);

        // lw 0x100, ready and response in their first cycles.
        stall_cnt     = 0;
        AluOutM       = 32'h0000_0100;
        MemReadM      = 1'b1;
        LoadWidthM    = 2'b10;
        bus_req_ready = 1'b1;
        settle();
        check_eq("lw_idle_stall", StallM, 32'd1);
        check_eq("lw_idle_valid", bus_req_valid, 32'd0);
        stall_cnt += int'(StallM);
        tick();
        settle();
        check_eq("lw_req_valid", bus_req_valid, 32'd1);
        check_eq("lw_req_addr",  bus_req_addr,  32'h0000_0100);
        check_eq("lw_req_we",    bus_req_we,    32'd0);
        stall_cnt += int'(StallM);
        tick();
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'hDEAD_BEEF;
        settle();
        check_eq("lw_wait_valid", bus_req_valid, 32'd0);
        stall_cnt += int'(StallM);
        tick();
        bus_rsp_valid = 1'b0;
        settle();
        stall_cnt += int'(StallM);
        check_eq("lw_done_stall", StallM,   32'd0);
        check_eq("lw_done_data",  RamDataM, 32'hDEAD_BEEF);
        check_eq("lw_stall_cnt",  stall_cnt, 32'd3);
        set_nop();
        tick();
        settle();
        check_eq("lw_back_idle", bus_req_valid, 32'd0);

        // sb 0x103: lane 3, and the response data must not reach RamDataM.
        AluOutM    = 32'h0000_0103;
        StoreDataM = 32'h0000_00AB;
        MemWriteM  = 4'b0001;
        settle();
        check_eq("sb_idle_stall", StallM, 32'd1);
        tick();
        settle();
        check_eq("sb_req_we",    bus_req_we,    32'd1);
        check_eq("sb_req_wstrb", bus_req_wstrb, 32'h8);
        check_eq("sb_req_wdata", bus_req_wdata, 32'hAB00_0000);
        check_eq("sb_req_addr",  bus_req_addr,  32'h0000_0100);
        tick();
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'h1234_5678;
        tick();
        bus_rsp_valid = 1'b0;
        settle();
        check_eq("sb_done_data",  RamDataM, 32'hDEAD_BEEF);
        check_eq("sb_done_stall", StallM,   32'd0);
        set_nop();
        tick();

        // Misaligned half and word accesses.
        AluOutM    = 32'h0000_0101;
        MemReadM   = 1'b1;
        LoadWidthM = 2'b01;
        settle();
        check_eq("lh_mis_flag",  AddrMisalignM, 32'd1);
        check_eq("lh_mis_stall", StallM,        32'd0);
        tick();
        settle();
        check_eq("lh_mis_valid", bus_req_valid, 32'd0);
        AluOutM    = 32'h0000_0102;
        LoadWidthM = 2'b10;
        settle();
        check_eq("lw_mis_flag", AddrMisalignM, 32'd1);
        tick();
        settle();
        check_eq("lw_mis_valid", bus_req_valid, 32'd0);
        check_eq("mis_ramdata",  RamDataM,      32'hDEAD_BEEF);
        set_nop();
        settle();
        check_eq("nop_mis_flag", AddrMisalignM, 32'd0);

        // lw 0x200, ready low 5 cycles, flush in the second REQ cycle.
        AluOutM       = 32'h0000_0200;
        MemReadM      = 1'b1;
        bus_req_ready = 1'b0;
        settle();
        tick();
        settle();
        check_eq("fl_req1_valid", bus_req_valid, 32'd1);
        tick();
        FlushM = 1'b1;
        settle();
        check_eq("fl_req2_valid", bus_req_valid, 32'd1);
        check_eq("fl_req2_stall", StallM,        32'd1);
        for (int i = 3; i <= 5; i++) begin
            tick();
            set_nop();
            settle();
            check_eq("fl_req_valid", bus_req_valid, 32'd1);
            check_eq("fl_req_addr",  bus_req_addr,  32'h0000_0200);
        end
        tick();
        bus_req_ready = 1'b1;
        settle();
        check_eq("fl_req6_valid", bus_req_valid, 32'd1);
        tick();
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'hCAFE_F00D;
        settle();
        check_eq("fl_wait_stall", StallM, 32'd1);
        tick();
        bus_rsp_valid = 1'b0;
        // Back in IDLE, a fresh load stalls immediately; DONE would not stall.
        AluOutM  = 32'h0000_0300;
        MemReadM = 1'b1;
        settle();
        check_eq("fl_no_done",  StallM,   32'd1);
        check_eq("fl_ramdata",  RamDataM, 32'hDEAD_BEEF);

        // lw 0x300, then EnM low for 3 DONE cycles.
        tick();
        settle();
        check_eq("en_req_addr", bus_req_addr, 32'h0000_0300);
        tick();
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'h1122_3344;
        tick();
        bus_rsp_valid = 1'b0;
        EnM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq("en_hold_stall", StallM,        32'd0);
            check_eq("en_hold_valid", bus_req_valid, 32'd0);
            check_eq("en_hold_data",  RamDataM,      32'h1122_3344);
            if (i < 2) begin
                tick();
            end
        end
        EnM = 1'b1;
        tick();
        set_nop();
        settle();
        check_eq("en_idle_valid", bus_req_valid, 32'd0);
        check_eq("en_idle_data",  RamDataM,      32'h1122_3344);

`ifdef MEM_TIMEOUT_EN
        // lw 0x400 with no response: watchdog fires after 4 WAIT cycles.
        AluOutM  = 32'h0000_0400;
        MemReadM = 1'b1;
        settle();
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            settle();
            check_eq("to_wait_buserr", BusErrM, 32'd0);
            check_eq("to_wait_stall",  StallM,  32'd1);
        end
        tick();
        settle();
        check_eq("to_buserr",  BusErrM,  32'd1);
        check_eq("to_ramdata", RamDataM, 32'd0);
        check_eq("to_stall",   StallM,   32'd0);
        set_nop();
        tick();
        settle();
        check_eq("to_buserr_pulse", BusErrM, 32'd0);
`endif

        // Reset in the middle of a transaction.
        AluOutM       = 32'h0000_0500;
        MemReadM      = 1'b1;
        bus_req_ready = 1'b0;
        settle();
        tick();
        settle();
        check_eq("mr_req_valid", bus_req_valid, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_nop();
        settle();
        check_eq("mr_valid",   bus_req_valid, 32'd0);
        check_eq("mr_ramdata", RamDataM,      32'd0);
        check_eq("mr_stall",   StallM,        32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fails);
        $finish;
    end

endmodule
